// File: rtl/shift_left_seq_pkg.sv
// Shared types and helpers for the sequential left shifter (package shift_pkg).
// The state type and the shift-amount saturation helper live here.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // A shift of more than the operand width is the same as shifting by the width.
  function automatic int unsigned sat_shamt(input int unsigned shamt, input int unsigned width);
    if (shamt > width) begin
      return width;
    end else begin
      return shamt;
    end
  endfunction

endpackage

// File: rtl/shift_left_seq_step.sv
// Single-bit left shift step (module shl_step_1bit). The sign_change output
// exists only when SHL_OVF_EN is defined.
module shl_step_1bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] wreg_in,
  output logic [WIDTH-1:0] wreg_out,
  output logic             msb_out
`ifdef SHL_OVF_EN
  , output logic           sign_change
`endif
);

  assign wreg_out = {wreg_in[WIDTH-2:0], 1'b0};
  assign msb_out  = wreg_in[WIDTH-1];

`ifdef SHL_OVF_EN
  // Two top bits differing before the shift means the sign bit is about to change.
  assign sign_change = wreg_in[WIDTH-1] ^ wreg_in[WIDTH-2];
`endif

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter: one bit per clock, start/busy/done handshake.
// Define SHL_OVF_EN to add the sticky signed-overflow flag output.
module shift_left_seq
  import shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SHW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag
`ifdef SHL_OVF_EN
  , output logic           overflow_flag
`endif
);

  shl_state_t       state;
  logic [WIDTH-1:0] wreg;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   sat_amt;
  logic [WIDTH-1:0] step_out;
  logic             msb_out;
`ifdef SHL_OVF_EN
  logic             sign_chg;
  logic             ovf_acc;
`endif

  shl_step_1bit #(.WIDTH(WIDTH)) u_step (
    .wreg_in  (wreg),
    .wreg_out (step_out),
    .msb_out  (msb_out)
`ifdef SHL_OVF_EN
    , .sign_change (sign_chg)
`endif
  );

  // Saturated shift amount for the operation being requested.
  always_comb begin
    sat_amt = SHW'(sat_shamt(32'(shamt), 32'(WIDTH)));
  end

  // FSM, working register, counter and published result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wreg       <= {WIDTH{1'b0}};
      cnt        <= {SHW{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= {WIDTH{1'b0}};
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
`ifdef SHL_OVF_EN
      ovf_acc       <= 1'b0;
      overflow_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wreg <= a;
            cnt  <= sat_amt;
`ifdef SHL_OVF_EN
            ovf_acc <= 1'b0;
`endif
            if (sat_amt == {SHW{1'b0}}) begin
              // Zero-length shift publishes the operand straight away.
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              result     <= a;
              carry_flag <= 1'b0;
              zero_flag  <= (a == {WIDTH{1'b0}});
`ifdef SHL_OVF_EN
              overflow_flag <= 1'b0;
`endif
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          wreg <= step_out;
          cnt  <= cnt - SHW'(1'b1);
`ifdef SHL_OVF_EN
          ovf_acc <= ovf_acc | sign_chg;
`endif
          if (cnt == SHW'(1'b1)) begin
            // Last step: publish the freshly shifted value, not the stale wreg.
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            result     <= step_out;
            carry_flag <= msb_out;
            zero_flag  <= (step_out == {WIDTH{1'b0}});
`ifdef SHL_OVF_EN
            overflow_flag <= ovf_acc | sign_chg;
`endif
          end else begin
            state <= SHIFT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
